lcd_mode_scheduler: RTL
=======================

# lcd_mode_scheduler

Frame-synchronous display-mode controller for the 480x272 LCD test-pattern generator. Debounces two user keys and runs an optional auto-cycle timer. Produces the 4-bit pattern-select code that the pattern generator decodes. Mode changes are committed only at a frame start, so a pattern never switches mid-frame. Sits in the `lcd_clk` (9 MHz) domain between the board keys, the timing generator's `lcd_vsync`, and the pattern mux.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 899_999: consecutive stable-low cycles required to accept a press (about 0.1 s at 9 MHz).
- `AUTO_FRAMES`, default 120: frames between auto-advances (2 s at 60 Hz); legal range 1..65535.
- `MODE_MAX`, default 13: highest mode code; mode wraps from `MODE_MAX` to 0.
- `DEFAULT_MODE`, default 12: reset mode (colour bars).

Ports:
- `lcd_clk`, in, 1: pixel clock; the only clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `key1`, in, 1: raw key input, active-low; each press advances to the next mode.
- `key2`, in, 1: raw key input, active-low; each press toggles auto-cycle.
- `lcd_vsync`, in, 1: vertical sync from the timing generator, active-low.
- `lcd_dis_mode`, out, 4: committed mode code, 0..`MODE_MAX`.
- `auto_on`, out, 1: auto-cycle enabled.
- `mode_changed`, out, 1: one-cycle pulse in the cycle `lcd_dis_mode` takes a new value.

## Operation
- **Synchroniser:** `key1` and `key2` each pass through a 2-flop synchroniser. Both flops reset to 1.
- **Debounce FSM, one per key:**
  - IDLE: move to PRESS_CNT when the synced key is 0.
  - PRESS_CNT: count while the key is 0. Return to IDLE if the key reads 1 before the count reaches `DEBOUNCE_CYC`. When the count reaches `DEBOUNCE_CYC`, move to HELD and emit a 1-cycle press event.
  - HELD: move to RELEASE_CNT when the key is 1.
  - RELEASE_CNT: return to HELD if the key reads 0. Move to IDLE after `DEBOUNCE_CYC` consecutive cycles with the key at 1.
  - Counter width is `$clog2(DEBOUNCE_CYC+1)`.
  - Holding a key produces exactly one event.
- **Frame start:** `vs_d` registers `lcd_vsync`. `frame_start = vs_d & ~lcd_vsync`, i.e. the falling edge of vsync.
- **Pending mode:** the `pending` register holds the mode to be shown next.
  - A key1 event sets `pending <= (pending==MODE_MAX) ? 0 : pending+1`.
  - Several presses within one frame accumulate, with wrap.
- **Auto-cycle:**
  - A key2 event toggles `auto_on` and clears `frame_cnt`.
  - While `auto_on` is 1, each `frame_start` increments `frame_cnt`, which is 16 bits.
  - When `frame_cnt` reaches `AUTO_FRAMES-1` on a `frame_start`, `frame_cnt` clears and an auto-advance occurs: `pending` increments with wrap.
  - A key1 event clears `frame_cnt`, so the auto timer restarts after a manual step.
- **Commit:** on `frame_start`, if `pending != lcd_dis_mode`:
  - `lcd_dis_mode <= pending`;
  - `mode_changed <= 1` for one cycle.
  - Otherwise `mode_changed` stays 0.
- **Simultaneous events in one cycle:**
  - key1 event with auto-advance: `pending` advances by one only, and `frame_cnt` clears.
  - key1 event with `frame_start`: the commit uses the pre-increment `pending`, and the new value commits at the next frame.
  - key2 event with `frame_start`: the toggle wins and `frame_cnt` clears. No auto-advance occurs in that cycle.
  - key1 and key2 events together: both take effect.
- **Reset:** asserting `rstn` at any time immediately drives:
  - `lcd_dis_mode = DEFAULT_MODE`, `pending = DEFAULT_MODE`;
  - `auto_on = 0`, `mode_changed = 0`, `frame_cnt = 0`;
  - both debounce FSMs to IDLE with counters at 0, and `vs_d = 1`.
  - Presses in progress are discarded.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Key press to event: 2 synchroniser cycles plus `DEBOUNCE_CYC` cycles, then 1 cycle.
- Press to visible mode change: the event latency above, then the next `frame_start` (at most one frame, 286×525 cycles), then 1 cycle.
- `frame_start` is asserted 1 cycle after vsync actually falls. The commit register updates on the following edge. The pattern generator therefore sees the new mode at vsync line 1 pixel 2, well inside the blanking region.
- `mode_changed` is high for exactly one cycle, aligned with the first cycle of the new `lcd_dis_mode`.
- `auto_on` updates 1 cycle after the key2 event.

## Test plan
Bench parameters: `DEBOUNCE_CYC=4`, `AUTO_FRAMES=3`, `MODE_MAX=13`, `DEFAULT_MODE=12`, with a short synthetic vsync.

1. **Reset:** hold `rstn=0` while toggling both keys and vsync → `lcd_dis_mode=12`, `auto_on=0`, `mode_changed=0`.
2. **Debounce:** key1 low for 3 cycles then high, repeated 5 times → no change. Then key1 low for 20 cycles → exactly one event, and at the next vsync fall `lcd_dis_mode=13` with one `mode_changed` pulse.
3. **Wrap and accumulation:** from mode 13, two valid presses within one frame → the next commit gives `lcd_dis_mode=1` (13→0→1), one pulse.
4. **Auto-cycle:** press key2 → `auto_on=1`. Over 3 vsync falls → the mode advances once per 3 frames: 12→13→0 after 3 and 6 frames. Press key2 again → `auto_on=0` and no further change over 10 frames.
5. **Collision:** with `auto_on=1`, force a key1 event in the same cycle as the auto-advance `frame_start` → `pending` advances by 1 only, and the next auto-advance comes 3 frames later.
6. **Mid-operation reset:** assert `rstn` during PRESS_CNT with `pending≠lcd_dis_mode` → immediate return to mode 12. After release, no event occurs until the key is released and pressed again for ≥4 cycles.

Source files
------------

// File: rtl/lcd_mode_scheduler.sv
// Frame-synchronous display-mode controller: debounced mode/auto keys, auto-cycle timer,
// and a pattern-select register that only changes on the falling edge of vsync.
module lcd_mode_scheduler #(
    parameter int unsigned DEBOUNCE_CYC = 899_999,
    parameter int unsigned AUTO_FRAMES  = 120,
    parameter int unsigned MODE_MAX     = 13,
    parameter int unsigned DEFAULT_MODE = 12
) (
    input  logic       lcd_clk,
    input  logic       rstn,
    input  logic       key1,
    input  logic       key2,
    input  logic       lcd_vsync,
    output logic [3:0] lcd_dis_mode,
    output logic       auto_on,
    output logic       mode_changed
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [15:0]   AUTO_LAST = 16'(AUTO_FRAMES - 1);
    localparam logic [3:0]    MODE_TOP  = 4'(MODE_MAX);
    localparam logic [3:0]    MODE_DEF  = 4'(DEFAULT_MODE);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CNT,
        HELD,
        RELEASE_CNT
    } db_state_t;

    // index 0 is key1 (mode step), index 1 is key2 (auto toggle)
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    db_state_t   st    [2];
    db_state_t   st_n  [2];
    logic [CW-1:0] cnt   [2];
    logic [CW-1:0] cnt_n [2];
    logic [1:0]  key_ev;

    logic        vs_d;
    logic        frame_start;
    logic        auto_adv;
    logic [3:0]  pending;
    logic [3:0]  pending_inc;
    logic [15:0] frame_cnt;

    always_ff @(posedge lcd_clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {key2, key1};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge lcd_clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < 2; k++) begin
                st[k]  <= IDLE;
                cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                st[k]  <= st_n[k];
                cnt[k] <= cnt_n[k];
            end
        end
    end

    // cnt holds the number of consecutive qualifying samples already seen
    always_comb begin
        key_ev = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            st_n[k]  = st[k];
            cnt_n[k] = cnt[k];
            case (st[k])
                IDLE: begin
                    if (!sync2[k]) begin
                        if (CNT_LAST == '0) begin
                            st_n[k]   = HELD;
                            key_ev[k] = 1'b1;
                        end else begin
                            st_n[k]  = PRESS_CNT;
                            cnt_n[k] = CNT_ONE;
                        end
                    end
                end
                PRESS_CNT: begin
                    if (sync2[k]) begin
                        st_n[k]  = IDLE;
                        cnt_n[k] = '0;
                    end else if (cnt[k] == CNT_LAST) begin
                        st_n[k]   = HELD;
                        cnt_n[k]  = '0;
                        key_ev[k] = 1'b1;
                    end else begin
                        cnt_n[k] = cnt[k] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (sync2[k]) begin
                        if (CNT_LAST == '0) begin
                            st_n[k] = IDLE;
                        end else begin
                            st_n[k]  = RELEASE_CNT;
                            cnt_n[k] = CNT_ONE;
                        end
                    end
                end
                RELEASE_CNT: begin
                    if (!sync2[k]) begin
                        st_n[k]  = HELD;
                        cnt_n[k] = '0;
                    end else if (cnt[k] == CNT_LAST) begin
                        st_n[k]  = IDLE;
                        cnt_n[k] = '0;
                    end else begin
                        cnt_n[k] = cnt[k] + CNT_ONE;
                    end
                end
                default: begin
                    st_n[k]  = IDLE;
                    cnt_n[k] = '0;
                end
            endcase
        end
    end

    // a key2 toggle in the same cycle suppresses the auto-advance
    always_comb begin
        frame_start = vs_d & ~lcd_vsync;
        auto_adv    = auto_on & frame_start & ~key_ev[1] & (frame_cnt == AUTO_LAST);
        pending_inc = (pending == MODE_TOP) ? '0 : pending + 4'd1;
    end

    always_ff @(posedge lcd_clk or negedge rstn) begin
        if (!rstn) begin
            vs_d         <= 1'b1;
            pending      <= MODE_DEF;
            lcd_dis_mode <= MODE_DEF;
            auto_on      <= 1'b0;
            mode_changed <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            vs_d         <= lcd_vsync;
            mode_changed <= 1'b0;
            if (frame_start && (pending != lcd_dis_mode)) begin
                lcd_dis_mode <= pending;
                mode_changed <= 1'b1;
            end
            if (key_ev[0] || auto_adv) begin
                pending <= pending_inc;
            end
            if (key_ev[1]) begin
                auto_on <= ~auto_on;
            end
            if (key_ev[0] || key_ev[1] || auto_adv) begin
                frame_cnt <= '0;
            end else if (auto_on && frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
